detect_event_logger: RTL and testbench
======================================

# detect_event_logger

Downstream consumer of the serial sequence detector's one-cycle match output. Each match is time-stamped with a free-running cycle counter, and the stamp is queued in a small first-word-fall-through FIFO for a host to read. The block also keeps a saturating total-match count and a sticky overflow flag. It shares the detector's clock domain and samples the detector output directly, with no synchronizer.

## Interface
- TS_WIDTH, 16, width of timestamp counter and FIFO entries
- DEPTH, 4, FIFO entries; power of two, ≥2
- CNT_WIDTH, 8, width of saturating match counter
- clk  in  1  clock; all state changes on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- match  in  1  detector output; one event per cycle it is high
- clear  in  1  synchronous clear of all state, highest priority after reset
- rd_en  in  1  pop head entry; ignored when empty
- ts_out  out  TS_WIDTH  head-of-FIFO timestamp; 0 when empty
- ts_valid  out  1  FIFO non-empty (equals !empty)
- empty  out  1  FIFO holds 0 entries
- full  out  1  FIFO holds DEPTH entries
- count  out  CNT_WIDTH  total matches since reset/clear, saturating
- overflow  out  1  sticky: a match was dropped because FIFO was full

## Operation
- Timestamp counter `ts`:
  - reset 0; +1 every cycle; wraps from all-ones to 0.
- Write:
  - when match=1 at an edge, the entry written is the `ts` value during that cycle, before the increment.
- Write acceptance:
  - accepted if !full, or if full and rd_en=1 in the same cycle (the pop frees the slot).
  - simultaneous read+write on full: occupancy stays DEPTH; the head advances; the new entry goes to the tail.
- Dropped write:
  - match=1, full=1, rd_en=0: entry discarded and overflow set to 1.
  - overflow stays set until clear or reset.
- Read:
  - FWFT; ts_out always shows the oldest entry.
  - rd_en=1 with !empty removes it at the edge.
  - rd_en with empty has no effect.
- Simultaneous read+write:
  - on a non-empty, non-full FIFO: occupancy unchanged.
  - on an empty FIFO: the write occurs; the read is ignored.
- count:
  - +1 on every match, including dropped ones.
  - holds at 2^CNT_WIDTH−1.
- clear=1 at an edge:
  - ts←0, FIFO emptied (pointers 0), count←0, overflow←0.
  - match and rd_en in that cycle are ignored.
- Storage: pointer-based circular buffer. Read and write pointers wrap modulo DEPTH. Occupancy is tracked with an extra pointer bit or a counter.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Stored entries are lost.

## Timing
- Reset values:
  - ts_out 0, ts_valid 0, empty 1, full 0, count 0, overflow 0.
  - internal ts 0, pointers 0.
- Write-to-visible latency: 1 cycle.
  - An entry written at edge k shows on ts_out (if it is the head) and deasserts empty after edge k.
- Read: after the edge with rd_en=1, ts_out shows the next entry, or 0 with empty=1.
- full, empty, count and overflow are registered and change only at clock edges.
- match may be high on consecutive cycles; each cycle is logged independently.
- match comes from combinational logic in the same clock domain and must be sampled only at the edge.

## Test plan
- Reset then idle 5 cycles:
  - empty=1, ts_valid=0, ts_out=0, count=0, overflow=0.
- Single match at ts=7:
  - next cycle ts_out=7, ts_valid=1, count=1.
  - rd_en one cycle → empty=1, ts_out=0.
- Matches at ts=3,4,5,6 (DEPTH=4), no reads:
  - full=1, count=4.
  - a further match at ts=9 → overflow=1, count=5, FIFO still holds 3,4,5,6.
  - four reads return 3,4,5,6 in order.
- Full FIFO holding 10,11,12,13; match and rd_en at ts=20:
  - full stays 1, overflow stays 0.
  - reads return 11,12,13,20.
- Force ts near wrap (TS_WIDTH=4): matches at ts=15 and the following cycle record 15 then 0.
  - 300 matches with CNT_WIDTH=8: count saturates at 255.
- clear asserted with FIFO holding 2 entries, overflow=1, plus simultaneous match:
  - next cycle empty=1, count=0, overflow=0, ts=0.
  - the match in the clear cycle is not logged.
  - Assert n_rst low mid-stream: all outputs return to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/detect_event_logger_if.sv
// Bus between the sequence-detector side (master) and the match event logger (slave).
// Carries the match strobe, host controls, and the FIFO/status view seen by the host.
interface detect_event_logger_if #(
  parameter int TS_WIDTH  = 16,
  parameter int CNT_WIDTH = 8
);
  logic                 match;
  logic                 clear;
  logic                 rd_en;
  logic [TS_WIDTH-1:0]  ts_out;
  logic                 ts_valid;
  logic                 empty;
  logic                 full;
  logic [CNT_WIDTH-1:0] count;
  logic                 overflow;

  modport master (
    output match, clear, rd_en,
    input  ts_out, ts_valid, empty, full, count, overflow
  );

  modport slave (
    input  match, clear, rd_en,
    output ts_out, ts_valid, empty, full, count, overflow
  );
endinterface

// File: rtl/detect_event_logger.sv
// Time-stamps each detector match with a free-running cycle counter and queues the stamp
// in a small FWFT FIFO; also keeps a saturating match count and a sticky drop flag.
module detect_event_logger #(
  parameter int TS_WIDTH  = 16,
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  n_rst,
  detect_event_logger_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [TS_WIDTH-1:0]  ts_reg;
  logic [TS_WIDTH-1:0]  mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]          occ_reg, occ_next;
  logic                 empty_reg, full_reg;
  logic [CNT_WIDTH-1:0] count_reg;
  logic                 overflow_reg;

  logic do_wr, do_rd, drop;

  // A pop on a full FIFO frees the slot the simultaneous write lands in.
  always_comb begin
    do_rd    = bus.rd_en && !empty_reg && !bus.clear;
    do_wr    = bus.match && (!full_reg || bus.rd_en) && !bus.clear;
    drop     = bus.match && full_reg && !bus.rd_en && !bus.clear;
    occ_next = occ_reg;
    if (do_wr && !do_rd)
      occ_next = occ_reg + 1'b1;
    else if (do_rd && !do_wr)
      occ_next = occ_reg - 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else if (bus.clear) begin
      ts_reg       <= '0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      occ_reg      <= '0;
      empty_reg    <= 1'b1;
      full_reg     <= 1'b0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      ts_reg    <= ts_reg + 1'b1;
      occ_reg   <= occ_next;
      empty_reg <= (occ_next == '0);
      full_reg  <= (occ_next == DEPTH_L);
      if (do_wr)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      // Dropped matches still count; only the count saturates.
      if (bus.match && (count_reg != {CNT_WIDTH{1'b1}}))
        count_reg <= count_reg + 1'b1;
      if (drop)
        overflow_reg <= 1'b1;
    end
  end

  // Entry storage carries no reset; stale contents are masked by empty.
  always_ff @(posedge clk) begin
    if (do_wr)
      mem[wr_ptr_reg] <= ts_reg;
  end

  assign bus.ts_out   = empty_reg ? '0 : mem[rd_ptr_reg];
  assign bus.ts_valid = !empty_reg;
  assign bus.empty    = empty_reg;
  assign bus.full     = full_reg;
  assign bus.count    = count_reg;
  assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_detect_event_logger.sv
// Directed bench for detect_event_logger: a 16-bit-stamp instance for FIFO/count/clear
// behaviour and a 4-bit-stamp instance for timestamp wrap.
module tb_detect_event_logger;
  logic clk;
  logic n_rst;

  detect_event_logger_if #(.TS_WIDTH(16), .CNT_WIDTH(8)) bus  ();
  detect_event_logger_if #(.TS_WIDTH(4),  .CNT_WIDTH(8)) bus2 ();

  detect_event_logger #(.TS_WIDTH(16), .DEPTH(4), .CNT_WIDTH(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  detect_event_logger #(.TS_WIDTH(4), .DEPTH(4), .CNT_WIDTH(8)) dut2 (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int tb_ts    = 0;   // stamp value the main instance holds during the current cycle
  int tb_ts2   = 0;   // same for the 4-bit instance

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    tb_ts  = bus.clear ? 0 : (tb_ts + 1) & 16'hFFFF;
    tb_ts2 = (tb_ts2 + 1) & 4'hF;
    #1;
  endtask

  task automatic wait_ts(input int target);
    int guard;
    guard = 0;
    while (tb_ts != target && guard < 200) begin
      step();
      guard++;
    end
    check("wait_ts_reached", tb_ts, target);
  endtask

  task automatic read_expect(input string tag, input int exp);
    check(tag, bus.ts_out, exp);
    bus.rd_en = 1'b1;
    step();
    bus.rd_en = 1'b0;
  endtask

  initial begin
    int guard;
    n_rst      = 1'b0;
    bus.match  = 1'b0; bus.clear  = 1'b0; bus.rd_en  = 1'b0;
    bus2.match = 1'b0; bus2.clear = 1'b0; bus2.rd_en = 1'b0;

    // Reset, then idle
    #12;
    n_rst = 1'b1;
    tb_ts = 0; tb_ts2 = 0;
    repeat (5) step();
    check("idle_empty",    bus.empty, 1);
    check("idle_ts_valid", bus.ts_valid, 0);
    check("idle_ts_out",   bus.ts_out, 0);
    check("idle_count",    bus.count, 0);
    check("idle_overflow", bus.overflow, 0);
    check("idle_full",     bus.full, 0);

    // Single match at ts=7, then read it out
    wait_ts(7);
    bus.match = 1'b1; step(); bus.match = 1'b0;
    check("single_ts_out",   bus.ts_out, 7);
    check("single_ts_valid", bus.ts_valid, 1);
    check("single_count",    bus.count, 1);
    read_expect("single_read", 7);
    check("single_empty_after", bus.empty, 1);
    check("single_ts_out_after", bus.ts_out, 0);

    // Fill with 3..6, then a dropped match at 9
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    wait_ts(3);
    bus.match = 1'b1; repeat (4) step(); bus.match = 1'b0;
    check("fill_full",  bus.full, 1);
    check("fill_count", bus.count, 4);
    check("fill_overflow_before", bus.overflow, 0);
    wait_ts(9);
    bus.match = 1'b1; step(); bus.match = 1'b0;
    check("drop_overflow", bus.overflow, 1);
    check("drop_count",    bus.count, 5);
    check("drop_full",     bus.full, 1);
    for (int i = 0; i < 4; i++) read_expect($sformatf("drop_read%0d", i), 3 + i);
    check("drop_empty_after", bus.empty, 1);
    check("drop_overflow_sticky", bus.overflow, 1);

    // Full FIFO 10..13, simultaneous read+write at ts=20
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    wait_ts(10);
    bus.match = 1'b1; repeat (4) step(); bus.match = 1'b0;
    wait_ts(20);
    bus.match = 1'b1; bus.rd_en = 1'b1; step(); bus.match = 1'b0; bus.rd_en = 1'b0;
    check("rw_full_full",     bus.full, 1);
    check("rw_full_overflow", bus.overflow, 0);
    check("rw_full_count",    bus.count, 5);
    read_expect("rw_read0", 11);
    read_expect("rw_read1", 12);
    read_expect("rw_read2", 13);
    read_expect("rw_read3", 20);
    check("rw_empty_after", bus.empty, 1);

    // Timestamp wrap on the 4-bit instance: 15 then 0
    guard = 0;
    while (tb_ts2 != 15 && guard < 20) begin step(); guard++; end
    check("wrap_reached", tb_ts2, 15);
    bus2.match = 1'b1; repeat (2) step(); bus2.match = 1'b0;
    check("wrap_count",  bus2.count, 2);
    check("wrap_first",  bus2.ts_out, 15);
    bus2.rd_en = 1'b1; step(); bus2.rd_en = 1'b0;
    check("wrap_second", bus2.ts_out, 0);
    check("wrap_valid",  bus2.ts_valid, 1);

    // Count saturation over 300 consecutive matches
    bus.clear = 1'b1; step(); bus.clear = 1'b0;
    bus.match = 1'b1;
    repeat (254) step();
    check("sat_count_254", bus.count, 254);
    step();
    check("sat_count_255", bus.count, 255);
    repeat (45) step();
    bus.match = 1'b0;
    check("sat_count_300", bus.count, 255);
    check("sat_overflow",  bus.overflow, 1);
    check("sat_full",      bus.full, 1);

    // Clear with 2 entries, overflow set, and a match in the clear cycle
    bus.rd_en = 1'b1; repeat (2) step(); bus.rd_en = 1'b0;
    check("pre_clear_full",  bus.full, 0);
    check("pre_clear_empty", bus.empty, 0);
    bus.clear = 1'b1; bus.match = 1'b1; step(); bus.clear = 1'b0;
    check("clear_empty",    bus.empty, 1);
    check("clear_count",    bus.count, 0);
    check("clear_overflow", bus.overflow, 0);
    step(); bus.match = 1'b0;
    check("clear_ts_zero",  bus.ts_out, 0);
    check("clear_ts_valid", bus.ts_valid, 1);
    check("clear_count_next", bus.count, 1);

    // Asynchronous reset mid-stream
    bus.match = 1'b1; bus2.match = 1'b1;
    repeat (3) step();
    #2;
    n_rst = 1'b0;
    #1;
    check("arst_ts_out",   bus.ts_out, 0);
    check("arst_ts_valid", bus.ts_valid, 0);
    check("arst_empty",    bus.empty, 1);
    check("arst_full",     bus.full, 0);
    check("arst_count",    bus.count, 0);
    check("arst_overflow", bus.overflow, 0);
    check("arst_count2",   bus2.count, 0);
    check("arst_empty2",   bus2.empty, 1);
    bus.match = 1'b0; bus2.match = 1'b0;
    #10;
    n_rst = 1'b1;
    tb_ts = 0; tb_ts2 = 0;
    step();
    check("post_arst_empty", bus.empty, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
